// File: rtl/timer_responder.sv
// timer_responder
//
// Memory-mapped countdown timer on the slave side of the CPU data bus.
// Decodes a 16-byte window at BASE_ADDR, serves word-granular loads and
// byte-enabled stores, and runs a countdown FSM whose registered irq
// output drives one bit of the CPU hwInt vector. Reads are combinational
// (zero wait states).
//
// Build option: define TIMER_PRESCALE_EN to turn offset 0xC into the
// PSC[15:0] prescale register. Each countdown step then happens only once
// every PSC+1 cycles. Without the macro, 0xC reads 0 and the prescaler is
// not built.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-low reset
//   addr    in  32   data-bus byte address
//   wdata   in  32   store data, already byte-lane aligned
//   byteen  in   4   store byte enables, 4'b0000 = no write
//   rdata   out 32   load data, combinational, 0 when not hit
//   hit     out  1   addr[31:4] matches BASE_ADDR[31:4]
//   irq     out  1   registered interrupt request (pending & IM)
//
// Register map (offset addr[3:2]):
//   0x0 CTRL    [0] EN, [2:1] MODE, [3] IM; upper bits read 0
//   0x4 PRESET  reload value
//   0x8 COUNT   current count, read-only
//   0xC PSC     prescale (TIMER_PRESCALE_EN only), else reads 0
//
// FSM states:
//   state  | meaning
//   IDLE   | stopped, waiting for EN
//   LOAD   | copy PRESET into COUNT (and reload the prescaler)
//   CNT    | step COUNT down; at zero raise pending
//   INT    | expiry: one-shot clears EN, auto-reload restarts

module timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_PSC    = 2'd3;

    localparam logic [1:0] MODE_AUTO  = 2'b01;

    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [1:0]  r_state;
    logic        r_pending;
    logic        r_irq;

    logic        w_hit;
    logic        w_we;
    logic        w_we_ctrl;
    logic        w_we_preset;
    logic        w_we_psc;
    logic        w_en_eff;
    logic        w_step;
    logic [31:0] w_psc_rd;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_set_pending;
    logic        w_clr_pending_fsm;
    logic        w_clr_en;
    logic        w_psc_reload;

    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_we        = w_hit & (|byteen);
    assign w_we_ctrl   = w_we && (addr[3:2] == OFF_CTRL);
    assign w_we_preset = w_we && (addr[3:2] == OFF_PRESET);
    assign w_we_psc    = w_we && (addr[3:2] == OFF_PSC);

    // EN as it will be after this edge. LOAD and CNT use it so that a
    // store clearing EN stops the FSM on that same edge and COUNT holds
    // the value the CPU last saw. IDLE uses the registered EN so start-up
    // latency stays one edge after the EN store.
    assign w_en_eff = (w_we_ctrl && byteen[0]) ? wdata[0] : r_ctrl[0];

    // ------------------------------------------------------------------
    // Optional prescaler
    // ------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
    logic [15:0] r_psc;
    logic [15:0] r_psc_cnt;
    logic [31:0] w_psc_merged;

    assign w_psc_merged = f_merge({16'd0, r_psc}, wdata, byteen);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psc <= 16'd0;
        end else if (w_we_psc) begin
            r_psc <= w_psc_merged[15:0];
        end
    end

    // Counts down between steps; a step fires when it reaches zero, and
    // it then reloads so steps are PSC+1 cycles apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psc_cnt <= 16'd0;
        end else if (w_psc_reload) begin
            r_psc_cnt <= r_psc;
        end else if ((r_state == S_CNT) && w_en_eff) begin
            if (r_psc_cnt == 16'd0) begin
                r_psc_cnt <= r_psc;
            end else begin
                r_psc_cnt <= r_psc_cnt - 16'd1;
            end
        end
    end

    assign w_step   = (r_psc_cnt == 16'd0);
    assign w_psc_rd = {16'd0, r_psc};
    assign w_unused = ^{addr[1:0], w_psc_merged[31:16]};
`else
    assign w_step   = 1'b1;
    assign w_psc_rd = 32'd0;
    assign w_unused = ^{addr[1:0], w_psc_reload, w_we_psc};
`endif

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_set_pending     = 1'b0;
        w_clr_pending_fsm = 1'b0;
        w_clr_en          = 1'b0;
        w_psc_reload      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_en_eff) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt  = r_preset;
                    w_psc_reload = 1'b1;
                    w_state_nxt  = S_CNT;
                end
            end
            S_CNT: begin
                if (!w_en_eff) begin
                    w_state_nxt = S_IDLE;
                end else if (w_step) begin
                    if (r_count == 32'd0) begin
                        w_set_pending = 1'b1;
                        w_state_nxt   = S_INT;
                    end else begin
                        w_count_nxt = r_count - 32'd1;
                    end
                end
            end
            S_INT: begin
                if (r_ctrl[2:1] == MODE_AUTO) begin
                    // Clearing pending here limits irq to a one-cycle pulse.
                    w_clr_pending_fsm = 1'b1;
                    w_state_nxt       = S_LOAD;
                end else begin
                    w_clr_en    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A CPU store to CTRL overrides the one-shot EN clear on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 4'd0;
        end else if (w_we_ctrl) begin
            if (byteen[0]) begin
                r_ctrl <= wdata[3:0];
            end
        end else if (w_clr_en) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= 32'd0;
        end else if (w_we_preset) begin
            r_preset <= f_merge(r_preset, wdata, byteen);
        end
    end

    // Any CTRL/PRESET store acknowledges the interrupt, and takes priority
    // over an expiry landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
        end else if (w_we_ctrl || w_we_preset) begin
            r_pending <= 1'b0;
        end else if (w_set_pending) begin
            r_pending <= 1'b1;
        end else if (w_clr_pending_fsm) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_pending & r_ctrl[3];
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        if (w_hit) begin
            case (addr[3:2])
                OFF_CTRL:   rdata = {28'd0, r_ctrl};
                OFF_PRESET: rdata = r_preset;
                OFF_COUNT:  rdata = r_count;
                OFF_PSC:    rdata = w_psc_rd;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign hit = w_hit;
    assign irq = r_irq;

endmodule

// File: tb/tb_timer_responder.sv
module tb_timer_responder;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSV    = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  byteen = 4'd0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    timer_responder #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w_addr;
        logic [31:0] w_data;
        logic [3:0]  w_be;
        logic [31:0] r_addr;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: present a bus transaction, commit it on the edge, then
    // stand 1 time unit past the edge so outputs are stable for sampling.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(a, d, 4'hF);
    endtask

    task automatic idle(input logic [31:0] a);
        cycle(a, 32'd0, 4'd0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        byteen = 4'd0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model: d = edges since the CTRL store that set EN.
    // LOAD occupies edge 1, COUNT = n after edge 2 and falls by one per edge;
    // the zero check, INT and (auto) LOAD give a reload period of n+3.
    function automatic logic [31:0] model_count(int n, bit auto_mode, int d);
        int q;
        if (auto_mode) begin
            q = (d - 1) % (n + 3);
            if (q == 0) return 32'd0;
            q = q - 1;
        end else begin
            if (d < 2) return 32'd0;
            q = d - 2;
        end
        return (q >= n) ? 32'd0 : 32'(n - q);
    endfunction

    function automatic logic model_irq(int n, bit auto_mode, bit im, int d);
        if (!im) return 1'b0;
        if (auto_mode) return (d > 1) && (((d - 1) % (n + 3)) == 0);
        return d >= n + 4;
    endfunction

    initial begin
        logic [31:0] v;
        logic [31:0] rsv_exp;
        int          n;
        logic [1:0]  mode;
        bit          im;
        bit          auto_mode;

`ifdef TIMER_PRESCALE_EN
        rsv_exp = 32'h0000_FFFF;
`else
        rsv_exp = 32'h0;
`endif
        vecs[0] = '{A_PRESET, 32'h1122_3344, 4'b1111, A_PRESET, 32'h1122_3344, 1'b1};
        vecs[1] = '{A_PRESET, 32'hAABB_CCDD, 4'b0011, A_PRESET, 32'h1122_CCDD, 1'b1};
        vecs[2] = '{A_PRESET, 32'h5500_0000, 4'b1000, A_PRESET, 32'h5522_CCDD, 1'b1};
        vecs[3] = '{A_COUNT,  32'hFFFF_FFFF, 4'b1111, A_COUNT,  32'h0,         1'b1};
        vecs[4] = '{A_CTRL,   32'hFFFF_FFF6, 4'b1111, A_CTRL,   32'h6,         1'b1};
        vecs[5] = '{A_CTRL,   32'hFFFF_FFFF, 4'b1110, A_CTRL,   32'h6,         1'b1};
        vecs[6] = '{32'h7E04, 32'hFFFF_FFFF, 4'b1111, A_PRESET, 32'h5522_CCDD, 1'b1};
        vecs[7] = '{A_RSV,    32'hFFFF_FFFF, 4'b1111, A_RSV,    rsv_exp,       1'b1};
        vecs[8] = '{32'h7E00, 32'h0,         4'b0000, 32'h7E00, 32'h0,         1'b0};
        vecs[9] = '{A_CTRL,   32'h0,         4'b0001, A_CTRL,   32'h0,         1'b1};

        // ---------------- reset state ----------------
        #2;
        check("irq in reset", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4 * i), v);
            check($sformatf("reset rd off%0d", 4 * i), v, 32'd0);
        end
        check("reset irq", {31'd0, irq}, 32'd0);
        rd(32'h0000_7E00, v);
        check("miss rdata", v, 32'd0);
        check("miss hit", {31'd0, hit}, 32'd0);

        // ---------------- register access table ----------------
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].w_addr, vecs[i].w_data, vecs[i].w_be);
            rd(vecs[i].r_addr, v);
            check($sformatf("vec%0d rdata", i), v, vecs[i].exp_rdata);
            check($sformatf("vec%0d hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
        end
        do_reset();

        // ---------------- one-shot, PRESET=5 ----------------
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        for (int d = 1; d <= 12; d++) begin
            idle(A_COUNT);
            check($sformatf("oneshot irq d%0d", d), {31'd0, irq}, (d >= 9) ? 32'd1 : 32'd0);
            check($sformatf("oneshot cnt d%0d", d), rdata, model_count(5, 1'b0, d));
        end
        rd(A_CTRL, v);
        check("oneshot ctrl EN cleared", v, 32'h8);
        wr(A_CTRL, 32'h8);
        check("irq held at ack edge", {31'd0, irq}, 32'd1);
        idle(A_COUNT);
        check("irq dropped after ack", {31'd0, irq}, 32'd0);

        // ---------------- async reset mid-count ----------------
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        idle(A_COUNT); idle(A_COUNT); idle(A_COUNT);
        check("pre-reset count", rdata, 32'd9);
        #1;
        reset = 1'b0;
        #1;
        check("async reset count", rdata, 32'd0);
        check("async reset irq", {31'd0, irq}, 32'd0);
        rd(A_CTRL, v);
        check("async reset ctrl", v, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ---------------- auto-reload, PRESET=2 ----------------
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int d = 1; d <= 17; d++) begin
            idle(A_COUNT);
            check($sformatf("auto irq d%0d", d), {31'd0, irq},
                  (d == 6 || d == 11 || d == 16) ? 32'd1 : 32'd0);
            if (d >= 2 && d <= 4) check($sformatf("auto cnt d%0d", d), rdata, 32'(4 - d));
            if (d >= 7 && d <= 9) check($sformatf("auto cnt2 d%0d", d), rdata, 32'(9 - d));
        end
        wr(A_CTRL, 32'h0);

        // ---------------- mid-count disable ----------------
        do_reset();
        wr(A_PRESET, 32'd6);
        wr(A_CTRL, 32'h9);
        for (int d = 1; d <= 5; d++) idle(A_COUNT);
        check("disable pre count", rdata, 32'd3);
        cycle(A_CTRL, 32'h0, 4'hF);
        for (int k = 0; k < 10; k++) begin
            idle(A_COUNT);
            check($sformatf("disable hold k%0d", k), rdata, 32'd3);
            check($sformatf("disable irq k%0d", k), {31'd0, irq}, 32'd0);
        end
        wr(A_COUNT, 32'h77);
        rd(A_COUNT, v);
        check("count write ignored", v, 32'd3);
        wr(A_CTRL, 32'h9);
        idle(A_COUNT); idle(A_COUNT);
        check("restart reloads", rdata, 32'd6);
        wr(A_CTRL, 32'h0);

        // ---------------- PRESET store during CNT ----------------
        do_reset();
        wr(A_PRESET, 32'd4);
        wr(A_CTRL, 32'h9);
        idle(A_COUNT); idle(A_COUNT); idle(A_COUNT);
        cycle(A_PRESET, 32'd100, 4'hF);
        rd(A_COUNT, v);
        check("preset mid-count d4", v, 32'd2);
        for (int d = 5; d <= 9; d++) begin
            idle(A_COUNT);
            check($sformatf("preset mid cnt d%0d", d), rdata, model_count(4, 1'b0, d));
            check($sformatf("preset mid irq d%0d", d), {31'd0, irq}, (d >= 8) ? 32'd1 : 32'd0);
        end

`ifdef TIMER_PRESCALE_EN
        // ---------------- prescale PSC=1 ----------------
        do_reset();
        wr(A_RSV, 32'd1);
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        for (int d = 1; d <= 10; d++) begin
            idle(A_COUNT);
            check($sformatf("psc irq d%0d", d), {31'd0, irq}, (d >= 9) ? 32'd1 : 32'd0);
            if (d >= 2) begin
                n = 2 - (d - 2) / 2;
                check($sformatf("psc cnt d%0d", d), rdata, (n < 0) ? 32'd0 : 32'(n));
            end
        end
`endif

        // ---------------- randomized trials ----------------
        for (int t = 0; t < 20; t++) begin
            n = (t == 0) ? 0 : int'($urandom_range(0, 12));
            mode = 2'($urandom_range(0, 3));
            im = 1'($urandom_range(0, 1));
            auto_mode = (mode == 2'b01);
            do_reset();
            wr(A_PRESET, 32'(n));
            wr(A_CTRL, {28'd0, im, mode, 1'b1});
            for (int d = 1; d <= 3 * (n + 3) + 4; d++) begin
                idle(A_COUNT);
                check($sformatf("rnd%0d irq d%0d", t, d), {31'd0, irq},
                      {31'd0, model_irq(n, auto_mode, im, d)});
                check($sformatf("rnd%0d cnt d%0d", t, d), rdata, model_count(n, auto_mode, d));
            end
            if (!auto_mode) begin
                rd(A_CTRL, v);
                check($sformatf("rnd%0d ctrl", t), v, {28'd0, im, mode, 1'b0});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
